// File: rtl/z16_pkg.sv
// Shared definitions for the Z16 fetch path: word widths, fetch FSM encodings
// and the sequential-PC helper.
package z16_pkg;

   localparam int Z16_WORD_W  = 16;
   localparam int Z16_ENTRY_W = 2 * Z16_WORD_W;
   localparam logic [Z16_WORD_W-1:0] Z16_NOP = 16'h0000;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_HALTED = 2'd2
   } fetch_state_e;

   // Instructions are 2 bytes; the 16-bit add wraps FFFE -> 0000 naturally.
   function automatic logic [Z16_WORD_W-1:0] z16_next_pc(input logic [Z16_WORD_W-1:0] pc);
      return pc + 16'd2;
   endfunction

endpackage

// File: rtl/z16_fetch_fifo.sv
// Circular prefetch buffer of {pc, instr} entries. Flush wins over push/pop;
// the head entry is presented straight from storage.
module z16_fetch_fifo
   import z16_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic                   i_flush,
   input  logic [Z16_ENTRY_W-1:0] i_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [Z16_ENTRY_W-1:0] o_head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
   logic [PTR_W:0]         count_q;
   logic [Z16_ENTRY_W-1:0] entry_w [DEPTH];
   logic                   wr_en;

   assign wr_en   = i_push && !i_flush;
   assign o_full  = (count_q == (PTR_W+1)'(DEPTH));
   assign o_empty = (count_q == '0);
   assign o_head  = entry_w[rd_ptr_q];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [Z16_ENTRY_W-1:0] entry_q;

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            entry_q <= {{Z16_WORD_W{1'b0}}, Z16_NOP};
         end else if (wr_en && (wr_ptr_q == PTR_W'(gi))) begin
            entry_q <= i_data;
         end
      end

      assign entry_w[gi] = entry_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (i_flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (i_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (i_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({i_push, i_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_push && !i_flush && o_full && !i_pop));
   a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_pop && !i_flush && o_empty));

endmodule

// File: rtl/z16_fetch_unit.sv
// Z16 instruction-fetch sequencer: owns the fetch PC, drives the zero-latency ROM
// and streams {pc, instr} to decode through the prefetch buffer.
module z16_fetch_unit
   import z16_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_halt,
   input  logic        i_redirect,
   input  logic [15:0] i_target,
   output logic [15:0] o_imem_addr,
   input  logic [15:0] i_imem_instr,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [15:0] o_instr,
   output logic [15:0] o_pc,
   output logic        o_busy
);

   fetch_state_e           state_q, state_d;
   logic [15:0]            pc_q, pc_d;
   logic                   run, pop, fetch, flush;
   logic                   buf_full, buf_empty;
   logic [Z16_ENTRY_W-1:0] head;

   assign run   = (state_q == S_RUN);
   assign pop   = o_valid && i_ready;
   // The word on the ROM bus this cycle is dropped when redirecting or halting.
   assign fetch = run && !i_redirect && !i_halt && (!buf_full || pop);
   assign flush = run && i_redirect;

   z16_fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (fetch),
      .i_pop   (pop),
      .i_flush (flush),
      .i_data  ({pc_q, i_imem_instr}),
      .o_full  (buf_full),
      .o_empty (buf_empty),
      .o_head  (head)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (i_start) state_d = S_RUN;
         S_RUN:    if (i_halt)  state_d = S_HALTED;
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pc_d = pc_q;
      if (i_redirect) begin
         pc_d = i_target & 16'hFFFE;
      end else if (fetch) begin
         pc_d = z16_next_pc(pc_q);
      end
   end

   assign o_imem_addr = pc_q;
   assign o_valid     = !buf_empty;
   assign o_pc        = head[Z16_ENTRY_W-1:Z16_WORD_W];
   assign o_instr     = head[Z16_WORD_W-1:0];
   assign o_busy      = run;

endmodule

// File: tb/tb_z16_fetch_unit.sv
// Bench for z16_fetch_unit: a queue-based reference model predicts buffer contents,
// a negedge monitor pops and compares on every decode handshake.
module tb_z16_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst, start, halt, redir, ready;
   logic [15:0] target;
   logic [15:0] imem_addr, imem_instr, o_instr, o_pc;
   logic        o_valid, o_busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] rom_word(input logic [15:0] a);
      case (a)
         16'h0000: return 16'h0040;
         16'h0002: return 16'h605D;
         16'h0004: return 16'h0000;
         16'h0006: return 16'h0000;
         16'h0008: return 16'h006C;
         default:  return (a * 16'h9E37) ^ 16'h5A5A;
      endcase
   endfunction

   assign imem_instr = rom_word(imem_addr);

   z16_fetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (16'h0000)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_halt       (halt),
      .i_redirect   (redir),
      .i_target     (target),
      .o_imem_addr  (imem_addr),
      .i_imem_instr (imem_instr),
      .o_valid      (o_valid),
      .i_ready      (ready),
      .o_instr      (o_instr),
      .o_pc         (o_pc),
      .o_busy       (o_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: state 0=idle 1=run 2=halted; exp_q holds the buffered {pc,instr}.
   int          m_state = 0;
   logic [15:0] m_pc = 16'h0000;
   logic [31:0] exp_q[$];
   bit          hs_q = 1'b0;
   int          m_occ;
   bit          m_take;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_state = 0;
         m_pc    = 16'h0000;
         exp_q.delete();
      end else begin
         m_occ  = exp_q.size() + (hs_q ? 1 : 0);
         m_take = (m_state == 1) && !redir && !halt && ((m_occ < DEPTH) || hs_q);
         if (redir && m_state == 1) exp_q.delete();
         if (m_take) begin
            exp_q.push_back({m_pc, rom_word(m_pc)});
            m_pc = m_pc + 16'd2;
         end
         if (redir) m_pc = {target[15:1], 1'b0};
         if (m_state == 0 && start)     m_state = 1;
         else if (m_state == 1 && halt) m_state = 2;
      end
   end

   // Monitor: compares DUT outputs with the model and retires the head on a handshake.
   always @(negedge clk) begin
      bit hs;
      hs = 1'b0;
      chk("valid", {31'd0, o_valid}, {31'd0, exp_q.size() != 0});
      chk("busy", {31'd0, o_busy}, {31'd0, m_state == 1});
      chk("imem_addr", {16'd0, imem_addr}, {16'd0, m_pc});
      if (exp_q.size() != 0) begin
         chk("head_pc", {16'd0, o_pc}, {16'd0, exp_q[0][31:16]});
         chk("head_instr", {16'd0, o_instr}, {16'd0, exp_q[0][15:0]});
         if (ready) begin
            $display("deliver pc=%h instr=%h%s", o_pc, o_instr, redir ? " (squashed)" : "");
            void'(exp_q.pop_front());
            hs = 1'b1;
         end
      end
      hs_q = hs;
   end

   task automatic drive(input logic st, input logic hl, input logic rd,
                        input logic [15:0] tg, input logic rdy);
      start  = st;
      halt   = hl;
      redir  = rd;
      target = tg;
      ready  = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start = 0; halt = 0; redir = 0; target = 16'h0; ready = 0;
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   initial begin
      rst = 1; start = 0; halt = 0; redir = 0; target = 16'h0; ready = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_instr", {16'd0, o_instr}, 32'd0);
      chk("rst_pc", {16'd0, o_pc}, 32'd0);
      chk("rst_imem_addr", {16'd0, imem_addr}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      rst = 0;

      // Start latency, then redirect to 0x0009 while head=0002.
      drive(1, 0, 0, 16'h0, 1);
      chk("t1_valid_edgeN", {31'd0, o_valid}, 32'd0);
      drive(0, 0, 0, 16'h0, 1);
      chk("t1_valid_edgeN1", {31'd0, o_valid}, 32'd1);
      chk("t1_pc0", {16'd0, o_pc}, 32'h0000);
      chk("t1_instr0", {16'd0, o_instr}, 32'h0040);
      drive(0, 0, 0, 16'h0, 1);
      chk("t1_pc1", {16'd0, o_pc}, 32'h0002);
      chk("t1_instr1", {16'd0, o_instr}, 32'h605D);
      drive(0, 0, 1, 16'h0009, 1);
      chk("t3_bubble", {31'd0, o_valid}, 32'd0);
      drive(0, 0, 0, 16'h0, 1);
      chk("t3_valid", {31'd0, o_valid}, 32'd1);
      chk("t3_pc", {16'd0, o_pc}, 32'h0008);
      chk("t3_instr", {16'd0, o_instr}, 32'h006C);
      drive(0, 0, 0, 16'h0, 1);

      // Back-pressure: fill, hold PC, release without gaps.
      do_reset();
      drive(1, 0, 0, 16'h0, 0);
      repeat (5) drive(0, 0, 0, 16'h0, 0);
      chk("t2_addr_hold", {16'd0, imem_addr}, 32'h0004);
      chk("t2_head", {16'd0, o_pc}, 32'h0000);
      drive(0, 0, 0, 16'h0, 1);
      chk("t2_rel1", {16'd0, o_pc}, 32'h0002);
      drive(0, 0, 0, 16'h0, 1);
      chk("t2_rel2", {16'd0, o_pc}, 32'h0004);

      // Halt with two entries buffered: drain, then stay idle-looking.
      do_reset();
      drive(1, 0, 0, 16'h0, 0);
      repeat (2) drive(0, 0, 0, 16'h0, 0);
      drive(0, 1, 0, 16'h0, 0);
      chk("t4_busy", {31'd0, o_busy}, 32'd0);
      chk("t4_still_valid", {31'd0, o_valid}, 32'd1);
      repeat (2) drive(0, 0, 0, 16'h0, 1);
      chk("t4_drained", {31'd0, o_valid}, 32'd0);
      drive(1, 0, 0, 16'h0, 1);
      drive(0, 0, 0, 16'h0, 1);
      chk("t4_start_ignored", {31'd0, o_busy}, 32'd0);
      chk("t4_no_refill", {31'd0, o_valid}, 32'd0);

      // Redirect to FFFE and wrap.
      do_reset();
      drive(1, 0, 0, 16'h0, 1);
      drive(0, 0, 0, 16'h0, 1);
      drive(0, 0, 1, 16'hFFFE, 1);
      drive(0, 0, 0, 16'h0, 1);
      chk("t5_pc_fffe", {16'd0, o_pc}, 32'hFFFE);
      drive(0, 0, 0, 16'h0, 1);
      chk("t5_pc_wrap", {16'd0, o_pc}, 32'h0000);

      // Asynchronous reset between edges, then restart.
      repeat (2) drive(0, 0, 0, 16'h0, 1);
      #2;
      rst = 1;
      #1;
      chk("t6_valid", {31'd0, o_valid}, 32'd0);
      chk("t6_addr", {16'd0, imem_addr}, 32'h0000);
      chk("t6_busy", {31'd0, o_busy}, 32'd0);
      @(posedge clk);
      #1;
      rst = 0;
      drive(1, 0, 0, 16'h0, 1);
      drive(0, 0, 0, 16'h0, 1);
      chk("t6_resume_pc", {16'd0, o_pc}, 32'h0000);
      chk("t6_resume_instr", {16'd0, o_instr}, 32'h0040);

      // Randomized traffic against the model.
      for (int r = 0; r < 4; r++) begin
         do_reset();
         drive(1, 0, 0, 16'h0, 1);
         for (int i = 0; i < 150; i++) begin
            drive($urandom_range(0, 99) < 5,
                  (i > 110) && ($urandom_range(0, 99) < 3),
                  $urandom_range(0, 99) < 6,
                  16'($urandom),
                  $urandom_range(0, 99) < 70);
         end
      end

      drive(0, 0, 0, 16'h0, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
